// File: rtl/veri_yolu_hakemi_pkg.sv
// Shared widths and FSM state encodings for the data-bus arbiter.
package veri_yolu_hakemi_pkg;

   localparam int unsigned VERI_BIT  = 32;
   localparam int unsigned VERI_BYTE = VERI_BIT / 8;

   localparam logic [1:0] BOSTA  = 2'd0;
   localparam logic [1:0] GONDER = 2'd1;
   localparam logic [1:0] YANIT  = 2'd2;

endpackage

// File: rtl/veri_yolu_hakemi_if.sv
// Requester-side and data-bus-unit-side signals of the arbiter; names are relative to the arbiter.
interface veri_yolu_hakemi_if
   import veri_yolu_hakemi_pkg::*;
#(
   parameter int unsigned ISTEKCI_SAYISI = 2
) ();

   logic [ISTEKCI_SAYISI-1:0]           ist_gecerli_i;
   logic [ISTEKCI_SAYISI-1:0]           ist_yaz_i;
   logic [ISTEKCI_SAYISI-1:0]           ist_oku_i;
   logic [ISTEKCI_SAYISI*VERI_BIT-1:0]  ist_adres_i;
   logic [ISTEKCI_SAYISI*VERI_BIT-1:0]  ist_veri_i;
   logic [ISTEKCI_SAYISI*VERI_BYTE-1:0] ist_maske_i;
   logic [ISTEKCI_SAYISI-1:0]           ist_hazir_o;
   logic [ISTEKCI_SAYISI-1:0]           yanit_gecerli_o;
   logic [VERI_BIT-1:0]                 yanit_veri_o;

   logic                                bib_istek_gecerli_o;
   logic                                bib_istek_yaz_o;
   logic                                bib_istek_oku_o;
   logic [VERI_BIT-1:0]                 bib_istek_adres_o;
   logic [VERI_BIT-1:0]                 bib_veri_o;
   logic [VERI_BYTE-1:0]                bib_istek_maske_o;
   logic                                bellek_hazir_i;
   logic [VERI_BIT-1:0]                 bellek_veri_i;
   logic                                bellek_gecerli_i;

   modport slave (
      input  ist_gecerli_i, ist_yaz_i, ist_oku_i, ist_adres_i, ist_veri_i, ist_maske_i,
      output ist_hazir_o, yanit_gecerli_o, yanit_veri_o,
      output bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o, bib_istek_adres_o,
      output bib_veri_o, bib_istek_maske_o,
      input  bellek_hazir_i, bellek_veri_i, bellek_gecerli_i
   );

   modport master (
      output ist_gecerli_i, ist_yaz_i, ist_oku_i, ist_adres_i, ist_veri_i, ist_maske_i,
      input  ist_hazir_o, yanit_gecerli_o, yanit_veri_o,
      input  bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o, bib_istek_adres_o,
      input  bib_veri_o, bib_istek_maske_o,
      output bellek_hazir_i, bellek_veri_i, bellek_gecerli_i
   );

endinterface

// File: rtl/veri_yolu_hakemi_oncelik_secici.sv
// Round-robin priority picker: first valid requester at or after the pointer, wrapping mod N.
module veri_yolu_hakemi_oncelik_secici #(
   parameter int unsigned ISTEKCI_SAYISI = 2,
   parameter int unsigned ISTEKCI_BIT    = 1
) (
   input  logic [ISTEKCI_SAYISI-1:0] i_gecerli,
   input  logic [ISTEKCI_BIT-1:0]    i_isaretci,
   output logic [ISTEKCI_SAYISI-1:0] o_izin,
   output logic [ISTEKCI_BIT-1:0]    o_indeks,
   output logic                      o_herhangi
);

   logic [ISTEKCI_BIT-1:0] w_aday;

   always_comb begin
      o_izin     = '0;
      o_indeks   = '0;
      o_herhangi = 1'b0;
      w_aday     = '0;
      for (int unsigned o = 0; o < ISTEKCI_SAYISI; o++) begin
         w_aday = ISTEKCI_BIT'((32'(i_isaretci) + o) % ISTEKCI_SAYISI);
         if (!o_herhangi && i_gecerli[w_aday]) begin
            o_herhangi     = 1'b1;
            o_indeks       = w_aday;
            o_izin[w_aday] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/veri_yolu_hakemi.sv
// Shares one data-bus unit between N requesters: round-robin grant, one transaction in flight,
// completion pulse and read data routed back to the owner.
module veri_yolu_hakemi
   import veri_yolu_hakemi_pkg::*;
#(
   parameter int unsigned ISTEKCI_SAYISI = 2,
   parameter int unsigned ISTEKCI_BIT    = 1
) (
   input logic               clk_i,
   input logic               rst_i,
   veri_yolu_hakemi_if.slave bus
);

   logic [1:0]                r_durum;
   logic [ISTEKCI_BIT-1:0]    r_isaretci;
   logic [ISTEKCI_BIT-1:0]    r_sahip;
   logic                      r_yaz;
   logic                      r_oku;
   logic                      r_bos;
   logic [VERI_BIT-1:0]       r_adres;
   logic [VERI_BIT-1:0]       r_veri;
   logic [VERI_BYTE-1:0]      r_maske;

   logic [ISTEKCI_SAYISI-1:0] w_izin;
   logic [ISTEKCI_BIT-1:0]    w_indeks;
   logic                      w_herhangi;
   logic                      w_kabul;
   logic                      w_tamam;
   logic                      w_gonder;
   logic                      w_yaz_sec;
   logic                      w_oku_sec;

   veri_yolu_hakemi_oncelik_secici #(
      .ISTEKCI_SAYISI(ISTEKCI_SAYISI),
      .ISTEKCI_BIT   (ISTEKCI_BIT)
   ) u_secici (
      .i_gecerli (bus.ist_gecerli_i),
      .i_isaretci(r_isaretci),
      .o_izin    (w_izin),
      .o_indeks  (w_indeks),
      .o_herhangi(w_herhangi)
   );

   assign w_kabul   = !rst_i && (r_durum == BOSTA) && bus.bellek_hazir_i && w_herhangi;
   // A no-op request (neither read nor write) completes on its own without the unit.
   assign w_tamam   = !rst_i && (r_durum == YANIT) && (bus.bellek_gecerli_i || r_bos);
   assign w_gonder  = !rst_i && (r_durum == GONDER);
   assign w_oku_sec = bus.ist_oku_i[w_indeks];
   assign w_yaz_sec = bus.ist_yaz_i[w_indeks] && !w_oku_sec;

   assign bus.ist_hazir_o         = w_kabul ? w_izin : '0;
   assign bus.bib_istek_gecerli_o = w_gonder;
   assign bus.bib_istek_yaz_o     = w_gonder && r_yaz;
   assign bus.bib_istek_oku_o     = w_gonder && r_oku;
   assign bus.bib_istek_adres_o   = w_gonder ? r_adres : '0;
   assign bus.bib_veri_o          = w_gonder ? r_veri  : '0;
   assign bus.bib_istek_maske_o   = w_gonder ? r_maske : '0;

   always_comb begin
      bus.yanit_gecerli_o = '0;
      bus.yanit_veri_o    = '0;
      if (w_tamam) begin
         bus.yanit_gecerli_o[r_sahip] = 1'b1;
         bus.yanit_veri_o             = r_bos ? '0 : bus.bellek_veri_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_durum    <= BOSTA;
         r_isaretci <= '0;
         r_sahip    <= '0;
         r_yaz      <= 1'b0;
         r_oku      <= 1'b0;
         r_bos      <= 1'b0;
         r_adres    <= '0;
         r_veri     <= '0;
         r_maske    <= '0;
      end else begin
         case (r_durum)
            BOSTA: begin
               if (w_kabul) begin
                  r_sahip <= w_indeks;
                  r_yaz   <= w_yaz_sec;
                  r_oku   <= w_oku_sec;
                  r_bos   <= !w_yaz_sec && !w_oku_sec;
                  r_adres <= bus.ist_adres_i[w_indeks*VERI_BIT +: VERI_BIT];
                  r_veri  <= bus.ist_veri_i[w_indeks*VERI_BIT +: VERI_BIT];
                  r_maske <= bus.ist_maske_i[w_indeks*VERI_BYTE +: VERI_BYTE];
                  r_durum <= (!w_yaz_sec && !w_oku_sec) ? YANIT : GONDER;
               end
            end
            GONDER: r_durum <= YANIT;
            YANIT: begin
               if (w_tamam) begin
                  r_isaretci <= (r_sahip == ISTEKCI_BIT'(ISTEKCI_SAYISI - 1)) ? '0
                                                                             : r_sahip + 1'b1;
                  r_bos      <= 1'b0;
                  r_durum    <= BOSTA;
               end
            end
            default: r_durum <= BOSTA;
         endcase
      end
   end

endmodule

// File: tb/tb_veri_yolu_hakemi.sv
// Directed bench for veri_yolu_hakemi: table of single transactions plus round-robin,
// unit-busy and mid-transaction reset sequences.
module tb_veri_yolu_hakemi;
   import veri_yolu_hakemi_pkg::*;

   localparam int unsigned N = 2;

   typedef struct {
      int unsigned k;
      logic        yaz;
      logic        oku;
      logic [31:0] adres;
      logic [31:0] veri;
      logic [3:0]  maske;
      int unsigned gecikme;
      logic [31:0] okuma;
      logic        bek_gonder;
      logic        bek_yaz;
      logic        bek_oku;
      logic [31:0] bek_veri;
   } vektor_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   kontrol_sayisi = 0;
   int   hata_sayisi = 0;

   always #5 clk = ~clk;

   veri_yolu_hakemi_if #(.ISTEKCI_SAYISI(N)) bus ();

   veri_yolu_hakemi #(
      .ISTEKCI_SAYISI(N),
      .ISTEKCI_BIT   (1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] bek);
      kontrol_sayisi++;
      if (gercek !== bek) begin
         hata_sayisi++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", ad, gercek, bek, $time);
      end
   endtask

   task automatic bosalt();
      bus.ist_gecerli_i    = '0;
      bus.ist_yaz_i        = '0;
      bus.ist_oku_i        = '0;
      bus.ist_adres_i      = '0;
      bus.ist_veri_i       = '0;
      bus.ist_maske_i      = '0;
      bus.bellek_hazir_i   = 1'b1;
      bus.bellek_veri_i    = '0;
      bus.bellek_gecerli_i = 1'b0;
   endtask

   task automatic islem(input vektor_t v);
      logic [N-1:0] bir;
      bir = 2'b01 << v.k;
      @(negedge clk);
      bosalt();
      bus.ist_gecerli_i                   = bir;
      bus.ist_yaz_i                       = v.yaz ? bir : '0;
      bus.ist_oku_i                       = v.oku ? bir : '0;
      bus.ist_adres_i[v.k*VERI_BIT +: VERI_BIT] = v.adres;
      bus.ist_veri_i[v.k*VERI_BIT +: VERI_BIT]  = v.veri;
      bus.ist_maske_i[v.k*VERI_BYTE +: VERI_BYTE] = v.maske;
      bus.bellek_veri_i                   = v.okuma;
      #1 kontrol("kabul", 32'(bus.ist_hazir_o), 32'(bir));
      @(negedge clk);
      bus.ist_gecerli_i = '0;
      #1 kontrol("bib_gecerli", 32'(bus.bib_istek_gecerli_o), 32'(v.bek_gonder));
      if (v.bek_gonder) begin
         kontrol("bib_yaz", 32'(bus.bib_istek_yaz_o), 32'(v.bek_yaz));
         kontrol("bib_oku", 32'(bus.bib_istek_oku_o), 32'(v.bek_oku));
         kontrol("bib_adres", bus.bib_istek_adres_o, v.adres);
         kontrol("bib_veri", bus.bib_veri_o, v.veri);
         kontrol("bib_maske", 32'(bus.bib_istek_maske_o), 32'(v.maske));
         bus.bellek_hazir_i = 1'b0;
         for (int i = 1; i < int'(v.gecikme); i++) begin
            @(negedge clk);
            #1 kontrol("erken_yanit", 32'(bus.yanit_gecerli_o), 32'(0));
         end
         @(negedge clk);
         bus.bellek_gecerli_i = 1'b1;
         #1;
      end
      kontrol("yanit_gecerli", 32'(bus.yanit_gecerli_o), 32'(bir));
      kontrol("yanit_veri", bus.yanit_veri_o, v.bek_veri);
      @(negedge clk);
      bus.bellek_gecerli_i = 1'b0;
      bus.bellek_hazir_i   = 1'b1;
      #1 kontrol("yanit_bitti", 32'(bus.yanit_gecerli_o), 32'(0));
      kontrol("yanit_veri_sifir", bus.yanit_veri_o, 32'(0));
   endtask

   vektor_t tablo [5];

   initial begin
      logic [N-1:0] bek_rr;

      tablo[0] = '{k: 0, yaz: 1, oku: 0, adres: 32'h80, veri: 32'hDEADBEEF, maske: 4'hF,
                   gecikme: 1, okuma: 32'h0, bek_gonder: 1, bek_yaz: 1, bek_oku: 0,
                   bek_veri: 32'h0};
      tablo[1] = '{k: 1, yaz: 0, oku: 1, adres: 32'h40, veri: 32'h0, maske: 4'hF,
                   gecikme: 5, okuma: 32'h12345678, bek_gonder: 1, bek_yaz: 0, bek_oku: 1,
                   bek_veri: 32'h12345678};
      tablo[2] = '{k: 1, yaz: 0, oku: 0, adres: 32'h44, veri: 32'h1111, maske: 4'h0,
                   gecikme: 0, okuma: 32'hA5A5A5A5, bek_gonder: 0, bek_yaz: 0, bek_oku: 0,
                   bek_veri: 32'h0};
      tablo[3] = '{k: 0, yaz: 1, oku: 1, adres: 32'h100, veri: 32'hCAFEF00D, maske: 4'h3,
                   gecikme: 2, okuma: 32'h0BADC0DE, bek_gonder: 1, bek_yaz: 0, bek_oku: 1,
                   bek_veri: 32'h0BADC0DE};
      tablo[4] = '{k: 1, yaz: 1, oku: 0, adres: 32'h200, veri: 32'h01020304, maske: 4'h8,
                   gecikme: 1, okuma: 32'h0, bek_gonder: 1, bek_yaz: 1, bek_oku: 0,
                   bek_veri: 32'h0};

      // Reset holds every output low even with a request pending.
      bosalt();
      bus.ist_gecerli_i = 2'b01;
      bus.ist_yaz_i     = 2'b01;
      repeat (3) @(negedge clk);
      #1 kontrol("reset_hazir", 32'(bus.ist_hazir_o), 32'(0));
      kontrol("reset_yanit", 32'(bus.yanit_gecerli_o), 32'(0));
      kontrol("reset_veri", bus.yanit_veri_o, 32'(0));
      kontrol("reset_bib", 32'(bus.bib_istek_gecerli_o), 32'(0));
      bosalt();
      rst = 1'b0;

      for (int i = 0; i < 5; i++) islem(tablo[i]);

      // Pointer is 0 here: two always-on requesters alternate 0,1,0,1,0,1.
      for (int t = 0; t < 6; t++) begin
         bek_rr = (t % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         bus.ist_gecerli_i    = 2'b11;
         bus.ist_yaz_i        = 2'b11;
         bus.bellek_gecerli_i = 1'b0;
         #1 kontrol("rr_izin", 32'(bus.ist_hazir_o), 32'(bek_rr));
         @(negedge clk);
         #1 kontrol("rr_gonderde_izin_yok", 32'(bus.ist_hazir_o), 32'(0));
         kontrol("rr_bib", 32'(bus.bib_istek_gecerli_o), 32'(1));
         @(negedge clk);
         bus.bellek_gecerli_i = 1'b1;
         #1 kontrol("rr_yanit", 32'(bus.yanit_gecerli_o), 32'(bek_rr));
      end
      @(negedge clk);
      bosalt();

      // Unit busy for 4 cycles, with a stale completion pulse while idle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.ist_gecerli_i    = 2'b01;
         bus.ist_yaz_i        = 2'b01;
         bus.bellek_hazir_i   = 1'b0;
         bus.bellek_gecerli_i = 1'b1;
         #1 kontrol("mesgul_izin_yok", 32'(bus.ist_hazir_o), 32'(0));
         kontrol("bayat_yanit_yok", 32'(bus.yanit_gecerli_o), 32'(0));
      end
      @(negedge clk);
      bus.bellek_hazir_i   = 1'b1;
      bus.bellek_gecerli_i = 1'b0;
      #1 kontrol("hazir_yukseldi_izin", 32'(bus.ist_hazir_o), 32'(2'b01));
      @(negedge clk);
      bus.ist_gecerli_i = '0;
      #1 kontrol("hazir_bib", 32'(bus.bib_istek_gecerli_o), 32'(1));
      @(negedge clk);
      bus.bellek_gecerli_i = 1'b1;
      #1 kontrol("hazir_yanit", 32'(bus.yanit_gecerli_o), 32'(2'b01));
      @(negedge clk);
      bosalt();

      // Pointer is 1: p1 reads, reset lands in YANIT, the late pulse must be dropped.
      bus.ist_gecerli_i = 2'b10;
      bus.ist_oku_i     = 2'b10;
      #1 kontrol("rst_oncesi_izin", 32'(bus.ist_hazir_o), 32'(2'b10));
      @(negedge clk);
      bosalt();
      bus.bellek_hazir_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 kontrol("rst_yanit_yok", 32'(bus.yanit_gecerli_o), 32'(0));
      kontrol("rst_bib_yok", 32'(bus.bib_istek_gecerli_o), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      bus.bellek_gecerli_i = 1'b1;
      bus.bellek_veri_i    = 32'hFFFFFFFF;
      #1 kontrol("gec_yanit_yok", 32'(bus.yanit_gecerli_o), 32'(0));
      kontrol("gec_veri_sifir", bus.yanit_veri_o, 32'(0));
      kontrol("gec_bib_yok", 32'(bus.bib_istek_gecerli_o), 32'(0));
      @(negedge clk);
      bosalt();
      bus.ist_gecerli_i = 2'b11;
      bus.ist_yaz_i     = 2'b11;
      #1 kontrol("rst_sonrasi_isaretci0", 32'(bus.ist_hazir_o), 32'(2'b01));
      @(negedge clk);
      bosalt();

      $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
      $finish;
   end

endmodule
